// File: rtl/sram_writer.sv
// Write-side controller for the DE2-115 IS61WV102416 async SRAM: single-word writes over
// a valid/ready handshake, plus a FILL mode that loads a block with a known pattern.
module sram_writer #(
    parameter int          WE_CYCLES = 1,
    parameter logic [19:0] FILL_BASE = 20'h00000,
    parameter int          FILL_LEN  = 16,
    parameter logic [15:0] FILL_XOR  = 16'h0000
) (
    input  logic        CLOCK_50,
    input  logic [0:0]  KEY,
    input  logic        WR_VALID,
    output logic        WR_READY,
    input  logic [19:0] WR_ADDR,
    input  logic [15:0] WR_DATA,
    input  logic [1:0]  WR_BE,
    output logic        WR_DONE,
    input  logic        FILL_START,
    output logic        FILL_BUSY,
    output logic        FILL_DONE,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);

    localparam int               CNT_W     = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WE_LAST   = CNT_W'(WE_CYCLES - 1);
    localparam logic [20:0]      FILL_LAST = 21'(FILL_LEN - 1);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [20:0]      idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_mode_q, fill_mode_d;
    logic [19:0]      addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic [1:0]       be_q, be_d;
    logic             drive_q, drive_d;
    logic             we_n_q, we_n_d;
    logic             ce_n_q, ce_n_d;
    logic             lb_n_q, lb_n_d;
    logic             ub_n_q, ub_n_d;
    logic             wr_done_q, wr_done_d;
    logic             fill_done_q, fill_done_d;
    logic             fill_busy_q, fill_busy_d;

    assign idx_inc = idx_q + 21'd1;

    // Every bus pin is registered, so next values are formed here one cycle ahead of the state they belong to.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fill_mode_d = fill_mode_q;
        addr_d      = addr_q;
        data_d      = data_q;
        be_d        = be_q;
        drive_d     = drive_q;
        we_n_d      = 1'b1;
        ce_n_d      = ce_n_q;
        lb_n_d      = lb_n_q;
        ub_n_d      = ub_n_q;
        wr_done_d   = 1'b0;
        fill_done_d = 1'b0;
        fill_busy_d = fill_busy_q;

        case (state_q)
            IDLE: begin
                ce_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                drive_d = 1'b0;
                if (FILL_START) begin
                    state_d     = SETUP;
                    fill_mode_d = 1'b1;
                    fill_busy_d = 1'b1;
                    idx_d       = 21'd0;
                    addr_d      = FILL_BASE;
                    data_d      = FILL_XOR;
                    be_d        = 2'b11;
                    drive_d     = 1'b1;
                    ce_n_d      = 1'b0;
                    lb_n_d      = 1'b0;
                    ub_n_d      = 1'b0;
                end else if (WR_VALID) begin
                    state_d     = SETUP;
                    fill_mode_d = 1'b0;
                    addr_d      = WR_ADDR;
                    data_d      = WR_DATA;
                    be_d        = WR_BE;
                    drive_d     = 1'b1;
                    ce_n_d      = 1'b0;
                    lb_n_d      = ~WR_BE[0];
                    ub_n_d      = ~WR_BE[1];
                end
            end
            SETUP: begin
                state_d = WRITE;
                cnt_d   = '0;
                we_n_d  = ~(|be_q);
            end
            WRITE: begin
                if (cnt_q == WE_LAST) begin
                    state_d     = HOLD;
                    wr_done_d   = ~fill_mode_q;
                    fill_done_d = fill_mode_q && (idx_q == FILL_LAST);
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    we_n_d = ~(|be_q);
                end
            end
            HOLD: begin
                if (fill_mode_q && (idx_q != FILL_LAST)) begin
                    state_d = SETUP;
                    idx_d   = idx_inc;
                    addr_d  = FILL_BASE + idx_inc[19:0];
                    data_d  = idx_inc[15:0] ^ FILL_XOR;
                end else begin
                    state_d     = IDLE;
                    fill_mode_d = 1'b0;
                    fill_busy_d = 1'b0;
                    drive_d     = 1'b0;
                    ce_n_d      = 1'b1;
                    lb_n_d      = 1'b1;
                    ub_n_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            state_q     <= IDLE;
            idx_q       <= 21'd0;
            cnt_q       <= '0;
            fill_mode_q <= 1'b0;
            addr_q      <= 20'd0;
            data_q      <= 16'd0;
            be_q        <= 2'b00;
            drive_q     <= 1'b0;
            we_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            wr_done_q   <= 1'b0;
            fill_done_q <= 1'b0;
            fill_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fill_mode_q <= fill_mode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            drive_q     <= drive_d;
            we_n_q      <= we_n_d;
            ce_n_q      <= ce_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
            wr_done_q   <= wr_done_d;
            fill_done_q <= fill_done_d;
            fill_busy_q <= fill_busy_d;
        end
    end

    assign WR_READY  = (state_q == IDLE) && !FILL_START;
    assign WR_DONE   = wr_done_q;
    assign FILL_DONE = fill_done_q;
    assign FILL_BUSY = fill_busy_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ   = drive_q ? data_q : 16'hzzzz;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = 1'b1;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_LB_N = lb_n_q;
    assign SRAM_UB_N = ub_n_q;

endmodule

// File: tb/tb_sram_writer.sv
// Scoreboard bench for sram_writer: directed and random writes and fills, checked against
// expected-event queues and a reference memory; a second instance covers address wrap and WE_CYCLES=2.
`timescale 1ns/1ps
module tb_sram_writer;

    localparam int          W_A    = 1;
    localparam int          LEN_A  = 16;
    localparam logic [19:0] BASE_A = 20'h00000;
    localparam logic [15:0] XOR_A  = 16'h0000;
    localparam int          W_B    = 2;
    localparam int          LEN_B  = 4;
    localparam logic [19:0] BASE_B = 20'hFFFFE;
    localparam logic [15:0] XOR_B  = 16'hFFFF;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic [0:0]  key_a;
    logic        wr_valid, wr_ready, wr_done, fill_start, fill_busy, fill_done;
    logic [19:0] wr_addr, sram_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, lb_n, ub_n;

    logic [0:0]  key_b;
    logic        wr_valid_b, wr_ready_b, wr_done_b, fill_start_b, fill_busy_b, fill_done_b;
    logic [19:0] wr_addr_b, sram_addr_b;
    logic [15:0] wr_data_b;
    logic [1:0]  wr_be_b;
    wire  [15:0] sram_dq_b;
    logic        we_n_b, oe_n_b, ce_n_b, lb_n_b, ub_n_b;

    sram_writer #(.WE_CYCLES(W_A), .FILL_BASE(BASE_A), .FILL_LEN(LEN_A), .FILL_XOR(XOR_A)) dut_a (
        .CLOCK_50(CLOCK_50), .KEY(key_a), .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_BE(wr_be), .WR_DONE(wr_done),
        .FILL_START(fill_start), .FILL_BUSY(fill_busy), .FILL_DONE(fill_done),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    sram_writer #(.WE_CYCLES(W_B), .FILL_BASE(BASE_B), .FILL_LEN(LEN_B), .FILL_XOR(XOR_B)) dut_b (
        .CLOCK_50(CLOCK_50), .KEY(key_b), .WR_VALID(wr_valid_b), .WR_READY(wr_ready_b),
        .WR_ADDR(wr_addr_b), .WR_DATA(wr_data_b), .WR_BE(wr_be_b), .WR_DONE(wr_done_b),
        .FILL_START(fill_start_b), .FILL_BUSY(fill_busy_b), .FILL_DONE(fill_done_b),
        .SRAM_ADDR(sram_addr_b), .SRAM_DQ(sram_dq_b), .SRAM_WE_N(we_n_b), .SRAM_OE_N(oe_n_b),
        .SRAM_CE_N(ce_n_b), .SRAM_LB_N(lb_n_b), .SRAM_UB_N(ub_n_b)
    );

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } bus_t;

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    bus_t      bus_q[$];
    int        done_q[$];
    int        fill_q[$];
    bit [15:0] ref_mem[int];
    bit [15:0] sram_mem[int];
    bit [15:0] sram_mem_b[int];
    bit        ignore_bus = 1'b0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void refWrite(input logic [19:0] addr, input logic [15:0] data, input logic [1:0] be);
        bit [15:0] w;
        w = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0000;
        if (be[0]) w[7:0]  = data[7:0];
        if (be[1]) w[15:8] = data[15:8];
        ref_mem[int'(addr)] = w;
    endfunction

    // Behavioural SRAM parts: store whichever bytes are enabled while WE_N and CE_N are low.
    always @(negedge CLOCK_50) begin
        bit [15:0] w;
        if (!we_n && !ce_n) begin
            w = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0000;
            if (!lb_n) w[7:0]  = sram_dq[7:0];
            if (!ub_n) w[15:8] = sram_dq[15:8];
            sram_mem[int'(sram_addr)] = w;
        end
        if (!we_n_b && !ce_n_b) begin
            w = sram_mem_b.exists(int'(sram_addr_b)) ? sram_mem_b[int'(sram_addr_b)] : 16'h0000;
            if (!lb_n_b) w[7:0]  = sram_dq_b[7:0];
            if (!ub_n_b) w[15:8] = sram_dq_b[15:8];
            sram_mem_b[int'(sram_addr_b)] = w;
        end
    end

    int   low_run = 0;
    int   busy_cycles = 0;
    bit   expect_busy_low = 1'b0;
    bus_t seen;

    always @(negedge CLOCK_50) begin
        bus_t e;
        if (ignore_bus) begin
            low_run = 0;
        end else if (!we_n) begin
            if (low_run == 0) begin
                seen.addr = sram_addr;
                seen.data = sram_dq;
                seen.be   = ~{ub_n, lb_n};
                checkOutput("ce_low_during_we", ce_n, 0);
            end else begin
                checkOutput("addr_stable_during_we", sram_addr, seen.addr);
                checkOutput("dq_stable_during_we", sram_dq, seen.data);
            end
            low_run++;
        end else if (low_run > 0) begin
            checkOutput("write_was_expected", 32'(bus_q.size() > 0), 1);
            if (bus_q.size() > 0) begin
                e = bus_q.pop_front();
                checkOutput("bus_addr", seen.addr, e.addr);
                checkOutput("bus_data", seen.data, e.data);
                checkOutput("bus_be", seen.be, e.be);
                checkOutput("we_low_cycles", low_run, W_A);
            end
            low_run = 0;
        end
        if (wr_done) begin
            checkOutput("wr_done_was_expected", 32'(done_q.size() > 0), 1);
            if (done_q.size() > 0) checkOutput("wr_done_cycle", cyc, done_q.pop_front());
        end
        if (expect_busy_low) begin
            checkOutput("busy_low_after_fill_done", fill_busy, 0);
            expect_busy_low = 1'b0;
        end
        if (fill_busy) busy_cycles++;
        if (fill_done) begin
            checkOutput("fill_done_was_expected", 32'(fill_q.size() > 0), 1);
            if (fill_q.size() > 0) checkOutput("fill_done_cycle", cyc, fill_q.pop_front());
            checkOutput("fill_busy_cycles", busy_cycles, LEN_A * (W_A + 2));
            busy_cycles = 0;
            expect_busy_low = 1'b1;
        end
    end

    int low_run_b = 0, pulses_b = 0, busy_b = 0, fill_done_cnt_b = 0, wr_done_cnt_b = 0;

    always @(negedge CLOCK_50) begin
        if (!we_n_b) begin
            low_run_b++;
        end else if (low_run_b > 0) begin
            checkOutput("b_we_low_cycles", low_run_b, W_B);
            pulses_b++;
            low_run_b = 0;
        end
        if (fill_busy_b) busy_b++;
        if (fill_done_b) fill_done_cnt_b++;
        if (wr_done_b) wr_done_cnt_b++;
    end

    task automatic pushWrite(input logic [19:0] addr, input logic [15:0] data, input logic [1:0] be);
        bus_t e;
        e.addr = addr;
        e.data = data;
        e.be   = be;
        if (be != 2'b00) bus_q.push_back(e);
        refWrite(addr, data, be);
        done_q.push_back(cyc + 2 + W_A);
    endtask

    task automatic applyStimulus(input logic [19:0] addr, input logic [15:0] data, input logic [1:0] be,
                                 output int acc_edge);
        int budget;
        budget = 0;
        acc_edge = -1;
        @(negedge CLOCK_50);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        wr_be    = be;
        while (!wr_ready && budget < 100) begin
            @(negedge CLOCK_50);
            budget++;
        end
        checkOutput("accept_within_budget", 32'(budget < 100), 1);
        if (budget < 100) begin
            acc_edge = cyc + 1;
            pushWrite(addr, data, be);
            @(posedge CLOCK_50);
        end
        #1 wr_valid = 1'b0;
    endtask

    task automatic applyFill(input bit with_write, input logic [19:0] addr, input logic [15:0] data,
                             input logic [1:0] be);
        int budget, start;
        bus_t e;
        budget = 0;
        @(negedge CLOCK_50);
        while (!wr_ready && budget < 100) begin
            @(negedge CLOCK_50);
            budget++;
        end
        fill_start = 1'b1;
        if (with_write) begin
            wr_valid = 1'b1;
            wr_addr  = addr;
            wr_data  = data;
            wr_be    = be;
        end
        #1 checkOutput("ready_low_with_fill_start", wr_ready, 0);
        start = cyc;
        for (int i = 0; i < LEN_A; i++) begin
            e.addr = BASE_A + 20'(i);
            e.data = 16'(i) ^ XOR_A;
            e.be   = 2'b11;
            bus_q.push_back(e);
            refWrite(e.addr, e.data, e.be);
        end
        fill_q.push_back(start + LEN_A * (W_A + 2));
        @(posedge CLOCK_50);
        #1 fill_start = 1'b0;
        if (with_write) begin
            budget = 0;
            @(negedge CLOCK_50);
            while (!wr_ready && budget < LEN_A * (W_A + 2) + 10) begin
                @(negedge CLOCK_50);
                budget++;
            end
            checkOutput("write_accept_after_fill", cyc, start + LEN_A * (W_A + 2) + 1);
            if (wr_ready) begin
                pushWrite(addr, data, be);
                @(posedge CLOCK_50);
            end
            #1 wr_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        @(negedge CLOCK_50);
        while ((!wr_ready || bus_q.size() != 0 || done_q.size() != 0 || fill_q.size() != 0) && budget < 200) begin
            @(negedge CLOCK_50);
            budget++;
        end
        checkOutput("idle_within_budget", 32'(budget < 200), 1);
    endtask

    task automatic checkResetA();
        checkOutput("rst_wr_ready", wr_ready, 1);
        checkOutput("rst_we_n", we_n, 1);
        checkOutput("rst_ce_n", ce_n, 1);
        checkOutput("rst_lb_ub_n", {lb_n, ub_n}, 2'b11);
        checkOutput("rst_oe_n", oe_n, 1);
        checkOutput("rst_addr", sram_addr, 0);
        checkOutput("rst_pulses", {wr_done, fill_done, fill_busy}, 3'b000);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e1, e2, dummy, budget;
        logic [19:0] ra;
        key_a = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; fill_start = 1'b0;
        key_b = 1'b0; wr_valid_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; wr_be_b = '0; fill_start_b = 1'b0;

        repeat (3) @(posedge CLOCK_50);
        #1;
        checkResetA();
        checkOutput("b_rst_state", {wr_ready_b, we_n_b, ce_n_b, oe_n_b, wr_done_b, fill_done_b, fill_busy_b},
                    7'b1111000);
        key_a = 1'b1;
        key_b = 1'b1;
        @(posedge CLOCK_50);
        #1 checkResetA();

        applyStimulus(20'h00003, 16'hBEEF, 2'b11, dummy);
        waitIdle();
        checkOutput("mem3_beef", sram_mem[3], 16'hBEEF);

        applyStimulus(20'h00005, 16'h1234, 2'b11, e1);
        applyStimulus(20'h00005, 16'hABCD, 2'b10, e2);
        checkOutput("back_to_back_spacing", e2 - e1, W_A + 3);
        applyStimulus(20'h00005, 16'h7777, 2'b00, dummy);
        waitIdle();
        checkOutput("mem5_ab34", sram_mem[5], 16'hAB34);

        applyFill(1'b0, '0, '0, '0);
        waitIdle();
        applyFill(1'b1, 20'h00021, 16'hC0DE, 2'b01);
        waitIdle();

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
            ra = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0)
                applyFill(1'($urandom_range(0, 1)), ra, 16'($urandom), 2'($urandom_range(0, 3)));
            else
                applyStimulus(ra, 16'($urandom), 2'($urandom_range(0, 3)), dummy);
        end
        waitIdle();

        // Reset asserted in the middle of a write must drop straight back to idle.
        ignore_bus = 1'b1;
        @(negedge CLOCK_50);
        wr_valid = 1'b1; wr_addr = 20'h00080; wr_data = 16'h5A5A; wr_be = 2'b11;
        checkOutput("abort_ready", wr_ready, 1);
        @(posedge CLOCK_50);
        #1 wr_valid = 1'b0;
        @(posedge CLOCK_50);
        #1 checkOutput("abort_we_low_in_write", we_n, 0);
        refWrite(20'h00080, 16'h5A5A, 2'b11);
        key_a = 1'b0;
        @(posedge CLOCK_50);
        #1 checkResetA();
        key_a = 1'b1;
        @(posedge CLOCK_50);
        #1 ignore_bus = 1'b0;
        waitIdle();

        foreach (ref_mem[a])
            checkOutput($sformatf("mem_%05h", a), sram_mem.exists(a) ? sram_mem[a] : 16'h0000, ref_mem[a]);

        @(negedge CLOCK_50);
        fill_start_b = 1'b1;
        @(posedge CLOCK_50);
        #1 fill_start_b = 1'b0;
        budget = 0;
        while (fill_done_cnt_b == 0 && budget < 200) begin
            @(negedge CLOCK_50);
            budget++;
        end
        checkOutput("b_fill_done_seen", 32'(fill_done_cnt_b > 0), 1);
        repeat (3) @(negedge CLOCK_50);
        checkOutput("b_fill_done_count", fill_done_cnt_b, 1);
        checkOutput("b_write_pulses", pulses_b, LEN_B);
        checkOutput("b_busy_cycles", busy_b, LEN_B * (W_B + 2));
        checkOutput("b_busy_dropped", fill_busy_b, 0);
        checkOutput("b_no_wr_done", wr_done_cnt_b, 0);
        for (int i = 0; i < LEN_B; i++) begin
            ra = BASE_B + 20'(i);
            checkOutput($sformatf("b_mem_%05h", ra),
                        sram_mem_b.exists(int'(ra)) ? sram_mem_b[int'(ra)] : 16'h0000, 16'(i) ^ XOR_B);
        end

        checkOutput("bus_queue_empty", bus_q.size(), 0);
        checkOutput("done_queue_empty", done_q.size(), 0);
        checkOutput("fill_queue_empty", fill_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
